// File: rtl/hist_capture_ctrl_if.sv
// Signal bundle around the histogram capture controller: command bytes in, UART TX bytes out,
// the shared BRAM port and the pulse-generator start/stop controls.
interface hist_capture_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic [7:0]            cmd_code;
  logic                  cmd_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  bram_owner;
  logic [ADDR_WIDTH-1:0] bram_address;
  logic                  bram_write_read;
  logic [DATA_WIDTH-1:0] bram_write_data;
  logic [DATA_WIDTH-1:0] bram_read_data;
  logic                  start_pulse_generator;
  logic                  stop_pulse_generator;
  logic                  pulse_gen_done;
  logic                  bram_reset_done;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_code, tx_ready, bram_read_data, pulse_gen_done,
    output cmd_ready, tx_data, tx_valid, bram_owner, bram_address, bram_write_read,
           bram_write_data, start_pulse_generator, stop_pulse_generator,
           bram_reset_done, busy
  );

  modport slave (
    output cmd_valid, cmd_code, tx_ready, bram_read_data, pulse_gen_done,
    input  cmd_ready, tx_data, tx_valid, bram_owner, bram_address, bram_write_read,
           bram_write_data, start_pulse_generator, stop_pulse_generator,
           bram_reset_done, busy
  );
endinterface

// File: rtl/hist_capture_ctrl.sv
// Command sequencer for histogram capture: decodes PC command bytes and sequences bin clear,
// capture start/stop and two-bytes-per-bin readout over the UART TX handshake.
module hist_capture_ctrl #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_BINS   = 512
) (
  input  logic                clk,
  input  logic                reset,
  hist_capture_ctrl_if.master bus
);

  localparam logic [7:0] CMD_CLEAR = 8'h43;
  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_STOP  = 8'h50;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] ERR_BYTE  = 8'hEE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_CAPTURE, ST_RD_ADDR, ST_RD_WAIT, ST_TX_HI, ST_TX_LO, ST_TX_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  cmd_fire;
  logic                  tx_fire;

  assign cmd_fire = bus.cmd_valid & cmd_ready_q;
  assign tx_fire  = tx_valid_q & bus.tx_ready;

  // Next state; every output flop is derived from the state being entered.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tx_data_d = tx_data_q;
    done_d    = done_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (bus.cmd_code)
            CMD_CLEAR: begin
              state_d = ST_CLEAR;
              addr_d  = '0;
              done_d  = 1'b0;
            end
            CMD_START: begin
              if (done_q) begin
                state_d = ST_CAPTURE;
                start_d = 1'b1;
              end else begin
                state_d   = ST_TX_ERR;
                tx_data_d = ERR_BYTE;
              end
            end
            CMD_READ: begin
              state_d = ST_RD_ADDR;
              addr_d  = '0;
            end
            CMD_STOP: state_d = ST_IDLE;
            default: begin
              state_d   = ST_TX_ERR;
              tx_data_d = ERR_BYTE;
            end
          endcase
        end
      end
      ST_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        // A stop command wins over a simultaneous done so the stop pulse is still issued.
        if (cmd_fire) begin
          if (bus.cmd_code == CMD_STOP) begin
            state_d = ST_IDLE;
            stop_d  = 1'b1;
          end else begin
            state_d   = ST_TX_ERR;
            tx_data_d = ERR_BYTE;
          end
        end else if (bus.pulse_gen_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        data_d    = bus.bram_read_data;
        tx_data_d = bus.bram_read_data[DATA_WIDTH-1 -: 8];
        state_d   = ST_TX_HI;
      end
      ST_TX_HI: begin
        if (tx_fire) begin
          tx_data_d = data_q[7:0];
          state_d   = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        if (tx_fire) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_TX_ERR: begin
        if (tx_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tx_valid_d  = (state_d == ST_TX_HI) || (state_d == ST_TX_LO) || (state_d == ST_TX_ERR);
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_CAPTURE);
    owner_d     = (state_d != ST_CAPTURE);
    wr_d        = (state_d == ST_CLEAR);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      owner_q     <= 1'b1;
      wr_q        <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      cmd_ready_q <= cmd_ready_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready             = cmd_ready_q;
  assign bus.tx_data               = tx_data_q;
  assign bus.tx_valid              = tx_valid_q;
  assign bus.bram_owner            = owner_q;
  assign bus.bram_address          = addr_q;
  assign bus.bram_write_read       = wr_q;
  assign bus.bram_write_data       = '0;
  assign bus.start_pulse_generator = start_q;
  assign bus.stop_pulse_generator  = stop_q;
  assign bus.bram_reset_done       = done_q;
  assign bus.busy                  = busy_q;

endmodule

// File: doc/hist_capture_ctrl.md
# hist_capture_ctrl

Command sequencer for the histogram capture system. It decodes single-byte commands received from the PC UART and sequences the histogram BRAM and pulse generator through four operations: clearing the bins, starting a capture, stopping it, and streaming every bin back to the PC. It sits between the UART RX/TX byte interfaces, the BRAM port shared with the histogram updater, and the pulse generator start/stop inputs.

## Interface
- ADDR_WIDTH, 9, BRAM address width.
- DATA_WIDTH, 16, bin width; fixed at 16 because readout sends two bytes per bin.
- NUM_BINS, 512, number of bins cleared and read out; must be ≤ 2^ADDR_WIDTH.
- clk  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  a received command byte is present.
- cmd_code  in  8  the received command byte.
- cmd_ready  out  1  controller accepts the byte this cycle.
- tx_data  out  8  byte to send to the PC.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte.
- bram_owner  out  1  1 = controller drives the BRAM port; 0 = histogram updater drives it.
- bram_address  out  ADDR_WIDTH  BRAM address.
- bram_write_read  out  1  1 = write, 0 = read.
- bram_write_data  out  DATA_WIDTH  BRAM write data; always 0.
- bram_read_data  in  DATA_WIDTH  BRAM read data; valid 1 cycle after the address is presented.
- start_pulse_generator  out  1  one-cycle start pulse.
- stop_pulse_generator  out  1  one-cycle stop pulse.
- pulse_gen_done  in  1  pulse generator has finished its burst (level or pulse).
- bram_reset_done  out  1  all bins are cleared since the last reset.
- busy  out  1  state is not IDLE.

## Operation
- Commands: 0x43 'C' = clear, 0x53 'S' = start, 0x50 'P' = stop, 0x52 'R' = readout.
- A command is accepted on a cycle where cmd_valid and cmd_ready are both high.
- cmd_ready is 1 in IDLE and CAPTURE, 0 in all other states.
- State machine states: IDLE, CLEAR, CAPTURE, RD_ADDR, RD_WAIT, TX_HI, TX_LO, TX_ERR.
- IDLE transitions:
  - 'C' → CLEAR, address 0; bram_reset_done drops to 0.
  - 'S' with bram_reset_done=1 → CAPTURE, with start_pulse_generator high for 1 cycle.
  - 'S' with bram_reset_done=0 → TX_ERR.
  - 'R' → RD_ADDR, address 0.
  - 'P' → no action.
  - Any other byte → TX_ERR.
- CLEAR: one write of 0 per cycle to addresses 0…NUM_BINS-1. After the last write, go to IDLE with bram_reset_done=1.
- CAPTURE:
  - bram_owner=0.
  - 'P' → stop_pulse_generator high for 1 cycle, then IDLE.
  - pulse_gen_done=1 → IDLE, no stop pulse.
  - Any other command → TX_ERR; the capture is aborted, without a stop pulse.
  - If 'P' and pulse_gen_done arrive in the same cycle: go to IDLE, and the stop pulse is still issued.
- RD_ADDR: drive the address with bram_write_read=0, then go to RD_WAIT.
- RD_WAIT: latch bram_read_data, then go to TX_HI.
- TX_HI: send data[15:8], then go to TX_LO.
- TX_LO: send data[7:0].
  - If address = NUM_BINS-1 → IDLE.
  - Otherwise increment the address → RD_ADDR.
- TX_ERR: send 0xEE, then go to IDLE.
- TX handshake:
  - tx_valid is held high with tx_data stable until tx_ready=1.
  - The transfer completes on that cycle, and the state advances on the next edge.
- The address counter never wraps past NUM_BINS-1.
- bram_owner is 1 in every state except CAPTURE.
- Reset, including mid-operation: go to IDLE and zero all outputs except bram_owner, which is 1. bram_reset_done=0. Any transfer in progress is abandoned.

## Timing
- Reset value of every output is 0, except bram_owner = 1.
- Clear takes NUM_BINS write cycles; bram_reset_done rises on the cycle after the last write (address NUM_BINS-1).
- start_pulse_generator and stop_pulse_generator are registered and asserted on the cycle after command acceptance.
- Readout costs 2 + (two handshake waits) cycles per bin. With tx_ready tied high, that is 4 cycles per bin.
- The first tx_valid appears 3 cycles after the 'R' command is accepted.
- A command arriving while cmd_ready=0 is not consumed; the upstream block keeps cmd_valid asserted.

## Test plan
- Clear, NUM_BINS=8: send 'C' → 8 consecutive writes of 0 to addresses 0…7; bram_reset_done=1 on the following cycle; busy=0.
- Start without clear after reset: send 'S' → tx byte 0xEE; no start pulse; returns to IDLE.
- Clear, then start, then stop: 'C', 'S', 'P' → one start pulse; bram_owner=0 during capture; one stop pulse; back to IDLE.
- Capture ending on its own: pulse_gen_done rises during CAPTURE → IDLE with no stop pulse. Also drive 'P' and pulse_gen_done in the same cycle → exactly one stop pulse.
- Readout with BRAM preloaded bin[i]=0x0100+i, NUM_BINS=4, tx_ready toggling every other cycle → byte stream 01 00 01 01 01 02 01 03; tx_data stays stable while waiting for tx_ready.
- Reset asserted mid-CLEAR (at address 3) and mid-readout → next cycle is IDLE with all outputs at reset values; a new 'C' restarts the clear from address 0.
